seg_scan_capture: RTL and testbench
===================================

# seg_scan_capture

Passive monitor on the multiplexed seven-segment display bus. It samples the segment and digit-select lines driven by the display scanner and decodes each digit's pattern back into a hex nibble. Once all eight digits of a scan have been seen, it reassembles the 32-bit displayed value. It sits beside the top-level display outputs: in simulation it checks the displayed value, and on-board it feeds the value to a loopback self-test.

## Interface
- SETTLE, default 4: cycles `sel_in` must hold a constant value before its digit is accepted (range 1..255).
- TIMEOUT, default 65535: cycles without a completed frame before `timeout` asserts.
- ACTIVE_LOW, default 1: when 1, both `seg_in` and `sel_in` are inverted before decoding (common-anode board).
- clk_in  input  1  sole clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high.
- seg_in  input  8  segment lines; bit0=a … bit6=g, bit7=dp.
- sel_in  input  8  digit select; bit k selects digit k, where digit 7 is the most significant nibble.
- value  output  32  last completed frame; nibble k comes from digit k.
- frame_valid  output  1  one-cycle pulse when `value` updates.
- stable  output  1  high while the last two completed frames were equal.
- bad_digit  output  1  sticky; set when an accepted pattern is not one of the 16 hex glyphs.
- timeout  output  1  level; high while no frame has completed within TIMEOUT cycles.

## Operation
- Normalization: `s = ACTIVE_LOW ? ~sel_in : sel_in`; segments are treated the same way.
- Only one-hot `s` is considered. A zero or multi-hot `s` is blanking: the settle counter clears and nothing is captured.
- Glyphs (gfedcba, active-high) map to nibbles 0–F:
  - 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F
  - A–F: 77 7C 39 5E 79 71
- The dp bit is ignored for decoding.
- FSM states:
  - WAIT: enter SETTLE when `s` is one-hot.
  - SETTLE: count while `s` and `seg` are unchanged from the previous cycle. Any change restarts the count in SETTLE, or returns to WAIT if `s` is not one-hot. When count == SETTLE, go to CAPTURE.
  - CAPTURE (1 cycle): write the decoded nibble into `frame[k]`, set `seen[k]`, go to HOLD.
  - HOLD: stay until `s` changes, then go to WAIT. This ensures one capture per select dwell.
- Unknown glyph: the nibble is written as 0, `seen[k]` is still set, and `bad_digit` is set.
- Completion: on the cycle after CAPTURE makes `seen` all-ones:
  - `value <= frame`, `frame_valid` pulses, `seen` clears.
  - `stable <= (frame == value_prev)`, where `value_prev` is the previous `value`.
  - The timeout counter clears and `timeout` deasserts.
- Re-capturing an already-seen digit before completion overwrites its nibble. `seen` is unchanged.
- Timeout counter saturates at TIMEOUT. `timeout` is high while the counter equals TIMEOUT.

## Timing
- Reset values:
  - Outputs: `value` = 0, `frame_valid` = 0, `stable` = 0, `bad_digit` = 0, `timeout` = 0.
  - Internal: `seen` = 0, FSM = WAIT, counters = 0.
- Capture latency: if `sel`/`seg` first take a new one-hot value at cycle t, CAPTURE occurs at t+SETTLE+1.
- `frame_valid` rises one cycle after the CAPTURE of the eighth distinct digit, and is high for exactly one cycle.
- Reset asserted mid-frame discards the partial frame. `bad_digit` clears only on reset.
- Same-cycle events: frame completion wins over timeout, so the counter clears and `timeout` stays low.

## Configuration
- `SEG_CAPTURE_DP_EN` defined:
  - Adds output `dp_out` (8 bits), the normalized dp bit captured per digit.
  - `dp_out` updates with `value` and is included in the `stable` comparison.
- Undefined: no `dp_out` port, and the dp bit is fully ignored.

## Structure
- Package `seg_pkg`:
  - the 16 glyph constants;
  - an FSM state enum (WAIT, SETTLE, CAPTURE, HOLD);
  - the digit count constant NDIG = 8.
- Sub-module `seg7_glyph_decode`: combinational, 7-bit glyph in → 4-bit nibble plus `known` flag. Instantiated once.

## Test plan
- Reset behaviour: after reset, all outputs are 0.
- Full scan, SETTLE=4, ACTIVE_LOW=1: each digit dwells 10 cycles to display 0x1234ABCD → `frame_valid` pulses once with `value` = 32'h1234ABCD. `stable` = 0; after a second identical scan, `stable` = 1.
- Glitch rejection: digit 3 dwells only 3 cycles, then the full scan completes → digit 3 is not captured until its next 10-cycle dwell, and `frame_valid` is delayed accordingly.
- Bad glyph: pattern 0x00 (active-high) shown on digit 5 → `bad_digit` = 1 and nibble 5 = 0. `bad_digit` stays 1 through later good frames until reset.
- Multi-hot and blank select: `sel` = 8'b0000_0011 or all-off for 20 cycles → no capture and no `frame_valid`.
- Timeout: TIMEOUT=100, scanning halted → `timeout` = 1 at cycle 100; it clears on the cycle `frame_valid` pulses after scanning resumes.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan monitor: glyph set, FSM states, digit count.
// Glyphs are active-high gfedcba patterns; the table is indexed by the nibble they display.
package seg_pkg;

    localparam int NDIG = 8;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    localparam logic [15:0][6:0] GLYPH_TABLE = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-to-nibble decoder; o_known is low (and the nibble 0) for any
// pattern that is not one of the sixteen hex glyphs.
module seg7_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_glyph,
    output logic [3:0] o_nibble,
    output logic       o_known
);

    always_comb begin
        o_nibble = 4'h0;
        o_known  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i_glyph == GLYPH_TABLE[i]) begin
                o_nibble = 4'(i);
                o_known  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Passive seven-segment scan monitor: settles each digit select, decodes its glyph, and
// publishes the 32-bit displayed value once all eight digits are seen. SEG_CAPTURE_DP_EN adds dp_out.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int SETTLE     = 4,
    parameter int TIMEOUT    = 65535,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [7:0]        seg_in,
    input  logic [NDIG-1:0]   sel_in,
    output logic [4*NDIG-1:0] value,
    output logic              frame_valid,
    output logic              stable,
    output logic              bad_digit,
    output logic              timeout
`ifdef SEG_CAPTURE_DP_EN
    ,
    output logic [NDIG-1:0]   dp_out
`endif
);

    localparam int               TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    TO_MAX   = TW'(TIMEOUT);
    localparam logic [8:0]       SETTLE_N = 9'(SETTLE);

    logic [NDIG-1:0]   w_s;
    logic [7:0]        w_seg_norm;
    logic [7:0]        w_seg;
    logic              w_onehot;
    logic              w_sel_chg;
    logic              w_any_chg;
    logic              w_complete;
    logic              w_same;
    logic [3:0]        w_nib;
    logic              w_known;
    logic [2:0]        w_idx;
    logic [8:0]        w_cnt_inc;
    state_t            w_state_nxt;
    logic [7:0]        w_cnt_nxt;

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic [NDIG-1:0]   r_s_prev;
    logic [7:0]        r_seg_prev;
    logic [4*NDIG-1:0] r_frame;
    logic [NDIG-1:0]   r_seen;
    logic [TW-1:0]     r_to_cnt;
`ifdef SEG_CAPTURE_DP_EN
    logic [NDIG-1:0]   r_dp;
`endif

    assign w_s        = ACTIVE_LOW ? ~sel_in : sel_in;
    assign w_seg_norm = ACTIVE_LOW ? ~seg_in : seg_in;
`ifdef SEG_CAPTURE_DP_EN
    assign w_seg      = w_seg_norm;
    assign w_same     = ({r_dp, r_frame} == {dp_out, value});
`else
    // dp is masked out so it can neither restart settling nor reach the frame
    assign w_seg      = {1'b0, w_seg_norm[6:0]};
    assign w_same     = (r_frame == value);
    logic w_unused_dp;
    assign w_unused_dp = w_seg_norm[7];
`endif

    assign w_onehot   = (w_s != '0) && ((w_s & (w_s - 1'b1)) == '0);
    assign w_sel_chg  = (w_s != r_s_prev);
    assign w_any_chg  = w_sel_chg || (w_seg != r_seg_prev);
    assign w_complete = &r_seen;
    assign w_cnt_inc  = {1'b0, r_cnt} + 9'd1;
    assign timeout    = (r_to_cnt == TO_MAX);

    // The settled select/segment values are the ones registered last cycle.
    seg7_glyph_decode u_decode (
        .i_glyph  (r_seg_prev[6:0]),
        .o_nibble (w_nib),
        .o_known  (w_known)
    );

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_s_prev[i]) w_idx = 3'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_WAIT: begin
                if (w_onehot) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (w_any_chg) begin
                    w_state_nxt = w_onehot ? ST_SETTLE : ST_WAIT;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == SETTLE_N) begin
                    w_state_nxt = ST_CAPTURE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc[7:0];
                end
            end
            ST_CAPTURE: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                // Leaving HOLD applies the WAIT decision in the same cycle, so a
                // digit-to-digit step keeps the same settle latency as from blank.
                if (w_sel_chg) begin
                    w_state_nxt = w_onehot ? ST_SETTLE : ST_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state     <= ST_WAIT;
            r_cnt       <= '0;
            r_s_prev    <= '0;
            r_seg_prev  <= '0;
            r_frame     <= '0;
            r_seen      <= '0;
            r_to_cnt    <= '0;
            value       <= '0;
            frame_valid <= 1'b0;
            stable      <= 1'b0;
            bad_digit   <= 1'b0;
`ifdef SEG_CAPTURE_DP_EN
            r_dp        <= '0;
            dp_out      <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_s_prev    <= w_s;
            r_seg_prev  <= w_seg;
            frame_valid <= 1'b0;

            if (w_complete) begin
                value       <= r_frame;
                frame_valid <= 1'b1;
                stable      <= w_same;
                r_seen      <= '0;
                r_to_cnt    <= '0;
`ifdef SEG_CAPTURE_DP_EN
                dp_out      <= r_dp;
`endif
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (r_state == ST_CAPTURE) begin
                r_frame[{w_idx, 2'b00} +: 4] <= w_known ? w_nib : 4'h0;
                r_seen[w_idx]                <= 1'b1;
                if (!w_known) bad_digit <= 1'b1;
`ifdef SEG_CAPTURE_DP_EN
                r_dp[w_idx] <= r_seg_prev[7];
`endif
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: table of full scans plus hand-written glitch, blanking,
// latency, reset and timeout sequences; expected frames are queued and checked on frame_valid.
module tb_seg_scan_capture;

    localparam int TB_SETTLE  = 4;
    localparam int TB_TIMEOUT = 100;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [7:0]  seg_in;
    logic [7:0]  sel_in;
    logic [31:0] value;
    logic        frame_valid;
    logic        stable;
    logic        bad_digit;
    logic        timeout;

    seg_scan_capture #(
        .SETTLE     (TB_SETTLE),
        .TIMEOUT    (TB_TIMEOUT),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .seg_in      (seg_in),
        .sel_in      (sel_in),
        .value       (value),
        .frame_valid (frame_valid),
        .stable      (stable),
        .bad_digit   (bad_digit),
        .timeout     (timeout)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] shown;
        int          bad_dig;
        logic [31:0] exp_val;
        logic        exp_stable;
        logic        exp_bad;
    } vec_t;

    vec_t        vecs [7];
    logic [6:0]  glyph [16];
    logic [32:0] sb_q [$];
    logic [32:0] mon_e;
    logic [31:0] m_last;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          n_fv   = 0;
    int          cyc    = 0;
    int          fv_cyc = 0;
    int          n0;
    int          c0;
    logic        prev_to   = 1'b0;
    logic        to_before = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    // Scoreboard side: every frame_valid pulse must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (frame_valid === 1'b1) begin
            n_fv++;
            fv_cyc    = cyc;
            to_before = prev_to;
            chk("frame_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("frame_value", value, mon_e[31:0]);
                chk("frame_stable", 32'(stable), 32'(mon_e[32]));
                chk("timeout_at_frame", 32'(timeout), 32'd0);
            end
        end
        prev_to = timeout;
    end

    task automatic drive(input int k, input logic [7:0] pat, input int dwell);
        logic [7:0] one;
        one    = 8'h01;
        sel_in = ~(one << k);
        seg_in = ~pat;
        repeat (dwell) @(posedge clk_in);
        #1;
    endtask

    task automatic blank(input int n);
        sel_in = 8'hFF;
        seg_in = 8'hFF;
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic show_nib(input int k, input logic [31:0] v);
        drive(k, {1'b0, glyph[v[4*k +: 4]]}, 10);
    endtask

    task automatic push_exp(input logic [31:0] v);
        sb_q.push_back({v == m_last, v});
        m_last = v;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_value"},       value,              32'd0);
        chk({tag, "_frame_valid"}, 32'(frame_valid),   32'd0);
        chk({tag, "_stable"},      32'(stable),        32'd0);
        chk({tag, "_bad_digit"},   32'(bad_digit),     32'd0);
        chk({tag, "_timeout"},     32'(timeout),       32'd0);
    endtask

    initial begin
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        vecs[0] = '{32'h1234ABCD, -1, 32'h1234ABCD, 1'b0, 1'b0};
        vecs[1] = '{32'h1234ABCD, -1, 32'h1234ABCD, 1'b1, 1'b0};
        vecs[2] = '{32'h0F0F5A5A, -1, 32'h0F0F5A5A, 1'b0, 1'b0};
        vecs[3] = '{32'hFEDC0987, -1, 32'hFEDC0987, 1'b0, 1'b0};
        vecs[4] = '{32'hFEDC0987, -1, 32'hFEDC0987, 1'b1, 1'b0};
        vecs[5] = '{32'h87654321,  5, 32'h87054321, 1'b0, 1'b1};
        vecs[6] = '{32'h87054321, -1, 32'h87054321, 1'b1, 1'b1};

        reset  = 1'b1;
        sel_in = 8'hFF;
        seg_in = 8'hFF;
        m_last = 32'd0;
        repeat (3) @(posedge clk_in);
        #1 reset = 1'b0;
        @(negedge clk_in);
        chk_reset_outputs("rst");
        @(posedge clk_in);
        #1;

        for (int i = 0; i < 7; i++) begin
            sb_q.push_back({vecs[i].exp_stable, vecs[i].exp_val});
            m_last = vecs[i].exp_val;
            for (int k = 0; k < 8; k++) begin
                if (k == vecs[i].bad_dig) drive(k, 8'h00, 10);
                else                      show_nib(k, vecs[i].shown);
            end
            chk("tbl_frame_done", sb_q.size(), 32'd0);
            chk("tbl_bad_digit", 32'(bad_digit), 32'(vecs[i].exp_bad));
        end

        // Digit 0 arrives from blank at cycle t: capture t+SETTLE+1, pulse visible two cycles later.
        for (int k = 1; k < 8; k++) show_nib(k, 32'h0BADF00D);
        blank(5);
        push_exp(32'h0BADF00D);
        c0 = cyc;
        show_nib(0, 32'h0BADF00D);
        chk("latency_cycles", fv_cyc - c0, TB_SETTLE + 3);
        chk("lat_frame_done", sb_q.size(), 32'd0);

        blank(3);
        n0 = n_fv;
        for (int k = 0; k < 3; k++) show_nib(k, 32'hCAFE1234);
        drive(3, {1'b0, glyph[4'hE]}, 3);
        for (int k = 4; k < 8; k++) show_nib(k, 32'hCAFE1234);
        chk("glitch_no_early_frame", n_fv, n0);
        push_exp(32'hCAFE1234);
        show_nib(3, 32'hCAFE1234);
        chk("glitch_frame_done", sb_q.size(), 32'd0);
        chk("glitch_one_frame", n_fv, n0 + 1);

        for (int k = 1; k < 8; k++) show_nib(k, 32'hCAFE1234);
        n0 = n_fv;
        sel_in = ~8'h03;
        seg_in = ~{1'b0, glyph[9]};
        repeat (20) @(posedge clk_in);
        #1;
        blank(20);
        chk("multihot_no_frame", n_fv, n0);
        push_exp(32'hCAFE1234);
        show_nib(0, 32'hCAFE1234);
        chk("multihot_frame_done", sb_q.size(), 32'd0);
        chk("bad_digit_sticky", 32'(bad_digit), 32'd1);

        for (int k = 0; k < 4; k++) show_nib(k, 32'h13579BDF);
        reset  = 1'b1;
        sel_in = 8'hFF;
        seg_in = 8'hFF;
        repeat (2) @(posedge clk_in);
        #1 reset = 1'b0;
        m_last = 32'd0;
        @(negedge clk_in);
        chk_reset_outputs("rst2");
        repeat (TB_TIMEOUT - 1) @(posedge clk_in);
        @(negedge clk_in);
        chk("timeout_before_limit", 32'(timeout), 32'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        chk("timeout_at_limit", 32'(timeout), 32'd1);
        @(posedge clk_in);
        #1;

        n0 = n_fv;
        for (int k = 4; k < 8; k++) show_nib(k, 32'h13579BDF);
        chk("reset_discard_partial", n_fv, n0);
        push_exp(32'h13579BDF);
        for (int k = 0; k < 4; k++) show_nib(k, 32'h13579BDF);
        chk("resume_frame_done", sb_q.size(), 32'd0);
        chk("timeout_held_until_frame", 32'(to_before), 32'd1);
        chk("timeout_after_frame", 32'(timeout), 32'd0);

        blank(5);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
